// File: rtl/mem_stage_access.sv
// Memory stage: issues a req/ack access to data memory for loads and stores, stalls
// the upstream pipeline while the access is outstanding and registers MEM/WB outputs.
module mem_stage_access #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead_In,
   input  logic              MemWrite_In,
   input  logic              MemtoReg_In,
   input  logic              RegWrite_In,
   input  logic [ADDR_W-1:0] Addr_In,
   input  logic [DATA_W-1:0] WriteData_In,
   input  logic [4:0]        Rd_In,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              Stall,
   output logic              RegWrite_Out,
   output logic              MemtoReg_Out,
   output logic [DATA_W-1:0] ReadData_Out,
   output logic [ADDR_W-1:0] ALUResult_Out,
   output logic [4:0]        Rd_Out,
   output logic              Err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] count_reg;
   logic             mem_op;
   logic             ack_hit;
   logic             timeout_hit;

   assign mem_op      = MemRead_In | MemWrite_In;
   assign ack_hit     = (state_reg == ACCESS) & mem_ack;
   // An ack on the last allowed cycle wins over the abort.
   assign timeout_hit = (state_reg == ACCESS) & ~mem_ack & (count_reg == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (mem_op) state_next = ACCESS;
         ACCESS:  if (ack_hit | timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_req = (state_reg == ACCESS);
      Stall   = mem_op & ~(ack_hit | timeout_hit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         count_reg     <= '0;
         RegWrite_Out  <= 1'b0;
         MemtoReg_Out  <= 1'b0;
         ReadData_Out  <= '0;
         ALUResult_Out <= '0;
         Rd_Out        <= '0;
         Err           <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (mem_op) begin
                  mem_addr     <= Addr_In;
                  mem_wdata    <= WriteData_In;
                  mem_we       <= MemWrite_In;
                  count_reg    <= '0;
                  RegWrite_Out <= 1'b0;
                  MemtoReg_Out <= 1'b0;
               end else begin
                  RegWrite_Out  <= RegWrite_In;
                  MemtoReg_Out  <= MemtoReg_In;
                  Rd_Out        <= Rd_In;
                  ALUResult_Out <= Addr_In;
                  ReadData_Out  <= '0;
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  RegWrite_Out  <= RegWrite_In;
                  MemtoReg_Out  <= MemtoReg_In;
                  Rd_Out        <= Rd_In;
                  ALUResult_Out <= Addr_In;
                  ReadData_Out  <= mem_we ? '0 : mem_rdata;
               end else if (timeout_hit) begin
                  // Abort: retire the instruction but suppress its register write.
                  RegWrite_Out  <= 1'b0;
                  MemtoReg_Out  <= MemtoReg_In;
                  Rd_Out        <= Rd_In;
                  ALUResult_Out <= Addr_In;
                  ReadData_Out  <= '0;
                  Err           <= 1'b1;
               end else begin
                  count_reg    <= count_reg + CNT_W'(1);
                  RegWrite_Out <= 1'b0;
                  MemtoReg_Out <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: reset, ALU pass-through, load, store,
// back-to-back loads and timeout abort, each checked against hand-computed values.
module tb_mem_stage_access;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemRead_In = 1'b0;
   logic        MemWrite_In = 1'b0;
   logic        MemtoReg_In = 1'b0;
   logic        RegWrite_In = 1'b0;
   logic [31:0] Addr_In = '0;
   logic [31:0] WriteData_In = '0;
   logic [4:0]  Rd_In = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        Stall;
   logic        RegWrite_Out;
   logic        MemtoReg_Out;
   logic [31:0] ReadData_Out;
   logic [31:0] ALUResult_Out;
   logic [4:0]  Rd_Out;
   logic        Err;

   int total = 0;
   int bad = 0;

   mem_stage_access #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
      .MemtoReg_In(MemtoReg_In), .RegWrite_In(RegWrite_In),
      .Addr_In(Addr_In), .WriteData_In(WriteData_In), .Rd_In(Rd_In),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .Stall(Stall), .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
      .ReadData_Out(ReadData_Out), .ALUResult_Out(ALUResult_Out), .Rd_Out(Rd_Out),
      .Err(Err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      MemRead_In = 0; MemWrite_In = 0; MemtoReg_In = 0; RegWrite_In = 0;
      Addr_In = '0; WriteData_In = '0; Rd_In = '0; mem_ack = 0; mem_rdata = '0;
   endtask

   task automatic test_reset();
      tick(); tick();
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, RegWrite_Out, MemtoReg_Out,
           ReadData_Out, ALUResult_Out, Rd_Out, Err} !== '0) begin
         bad++; $display("FAIL reset_state got nonzero outputs req=%0b we=%0b err=%0b", mem_req, mem_we, Err);
      end
      rst = 0;
      MemRead_In = 1; Addr_In = 32'h44; Rd_In = 5'd3; RegWrite_In = 1;
      tick();
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
         bad++; $display("FAIL reset_preaccess got req=%0b addr=%h exp req=1 addr=00000044", mem_req, mem_addr);
      end
      rst = 1;
      tick();
      total++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
         bad++; $display("FAIL reset_midaccess got req=%0b addr=%h exp req=0 addr=0", mem_req, mem_addr);
      end
      tick();
      total++;
      if (mem_req !== 1'b0 || RegWrite_Out !== 1'b0 || Err !== 1'b0) begin
         bad++; $display("FAIL reset_hold got req=%0b rw=%0b err=%0b exp all 0", mem_req, RegWrite_Out, Err);
      end
      rst = 0;
      clear_inputs();
      mem_ack = 1; mem_rdata = 32'h55;
      #1;
      total++;
      if (Stall !== 1'b0) begin
         bad++; $display("FAIL reset_late_ack_stall got=%0b exp=0", Stall);
      end
      tick();
      total++;
      if (mem_req !== 1'b0 || ReadData_Out !== 32'h0 || RegWrite_Out !== 1'b0) begin
         bad++; $display("FAIL reset_late_ack got req=%0b rdata=%h rw=%0b exp 0/0/0", mem_req, ReadData_Out, RegWrite_Out);
      end
      mem_ack = 0; mem_rdata = '0;
      $display("reset transaction checked");
   endtask

   task automatic test_alu();
      RegWrite_In = 1; Addr_In = 32'h10; Rd_In = 5'd5;
      #1;
      total++;
      if (Stall !== 1'b0) begin
         bad++; $display("FAIL alu_stall got=%0b exp=0", Stall);
      end
      tick();
      total++;
      if (RegWrite_Out !== 1'b1 || ALUResult_Out !== 32'h10 || Rd_Out !== 5'd5 ||
          ReadData_Out !== 32'h0 || mem_req !== 1'b0) begin
         bad++; $display("FAIL alu_wb got rw=%0b alu=%h rd=%0d rdata=%h req=%0b exp 1/10/5/0/0",
                         RegWrite_Out, ALUResult_Out, Rd_Out, ReadData_Out, mem_req);
      end
      clear_inputs();
      $display("alu transaction addr=10 rd=5 checked");
   endtask

   task automatic test_load();
      int stall_cnt = 0;
      MemRead_In = 1; MemtoReg_In = 1; RegWrite_In = 1; Addr_In = 32'h40; Rd_In = 5'd7;
      for (int cyc = 0; cyc < 5; cyc++) begin
         mem_ack = (cyc == 4);
         mem_rdata = (cyc == 4) ? 32'hDEADBEEF : 32'h0;
         #1;
         if (Stall === 1'b1) stall_cnt++;
         if (cyc >= 1) begin
            total++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || RegWrite_Out !== 1'b0) begin
               bad++; $display("FAIL load_access c%0d got req=%0b we=%0b addr=%h rw=%0b exp 1/0/40/0",
                               cyc, mem_req, mem_we, mem_addr, RegWrite_Out);
            end
         end
         tick();
      end
      total++;
      if (stall_cnt != 4) begin
         bad++; $display("FAIL load_stall_cycles got=%0d exp=4", stall_cnt);
      end
      total++;
      if (RegWrite_Out !== 1'b1 || MemtoReg_Out !== 1'b1 || ReadData_Out !== 32'hDEADBEEF ||
          Rd_Out !== 5'd7 || ALUResult_Out !== 32'h40) begin
         bad++; $display("FAIL load_wb got rw=%0b m2r=%0b rdata=%h rd=%0d alu=%h exp 1/1/deadbeef/7/40",
                         RegWrite_Out, MemtoReg_Out, ReadData_Out, Rd_Out, ALUResult_Out);
      end
      clear_inputs();
      #1;
      total++;
      if (mem_req !== 1'b0) begin
         bad++; $display("FAIL load_req_release got=%0b exp=0", mem_req);
      end
      tick();
      $display("load transaction addr=40 data=deadbeef checked");
   endtask

   task automatic test_store();
      MemWrite_In = 1; Addr_In = 32'h80; WriteData_In = 32'h1234; Rd_In = 5'd9;
      #1;
      total++;
      if (Stall !== 1'b1) begin
         bad++; $display("FAIL store_issue_stall got=%0b exp=1", Stall);
      end
      tick();
      mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
      #1;
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234 || mem_addr !== 32'h80 || Stall !== 1'b0) begin
         bad++; $display("FAIL store_access got req=%0b we=%0b wdata=%h addr=%h stall=%0b exp 1/1/1234/80/0",
                         mem_req, mem_we, mem_wdata, mem_addr, Stall);
      end
      tick();
      total++;
      if (ReadData_Out !== 32'h0 || RegWrite_Out !== 1'b0 || ALUResult_Out !== 32'h80) begin
         bad++; $display("FAIL store_wb got rdata=%h rw=%0b alu=%h exp 0/0/80", ReadData_Out, RegWrite_Out, ALUResult_Out);
      end
      clear_inputs();
      tick();
      $display("store transaction addr=80 data=1234 checked");
   endtask

   task automatic test_back_to_back();
      logic [3:0] req_seq = '0;
      MemRead_In = 1; MemtoReg_In = 1; RegWrite_In = 1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         Addr_In   = (cyc < 2) ? 32'h100 : 32'h104;
         Rd_In     = (cyc < 2) ? 5'd1 : 5'd2;
         mem_ack   = (cyc == 1) || (cyc == 3);
         mem_rdata = (cyc == 1) ? 32'hAAAA0001 : ((cyc == 3) ? 32'hBBBB0002 : 32'h0);
         #1;
         req_seq[cyc] = mem_req;
         tick();
         if (cyc == 1) begin
            total++;
            if (ReadData_Out !== 32'hAAAA0001 || Rd_Out !== 5'd1 || RegWrite_Out !== 1'b1) begin
               bad++; $display("FAIL b2b_first got rdata=%h rd=%0d rw=%0b exp aaaa0001/1/1", ReadData_Out, Rd_Out, RegWrite_Out);
            end
         end
         if (cyc == 2) begin
            total++;
            if (RegWrite_Out !== 1'b0) begin
               bad++; $display("FAIL b2b_bubble got rw=%0b exp=0", RegWrite_Out);
            end
         end
         if (cyc == 3) begin
            total++;
            if (ReadData_Out !== 32'hBBBB0002 || Rd_Out !== 5'd2 || ALUResult_Out !== 32'h104) begin
               bad++; $display("FAIL b2b_second got rdata=%h rd=%0d alu=%h exp bbbb0002/2/104", ReadData_Out, Rd_Out, ALUResult_Out);
            end
         end
      end
      total++;
      if (req_seq !== 4'b1010) begin
         bad++; $display("FAIL b2b_req_pattern got=%b exp=1010", req_seq);
      end
      clear_inputs();
      tick();
      $display("back-to-back loads 100/104 checked");
   endtask

   task automatic test_timeout();
      int req_cnt = 0;
      int stall_cnt = 0;
      total++;
      if (Err !== 1'b0) begin
         bad++; $display("FAIL timeout_err_before got=%0b exp=0", Err);
      end
      MemRead_In = 1; MemtoReg_In = 1; RegWrite_In = 1; Addr_In = 32'h200; Rd_In = 5'd9;
      for (int cyc = 0; cyc < 5; cyc++) begin
         #1;
         if (mem_req === 1'b1) req_cnt++;
         if (Stall === 1'b1) stall_cnt++;
         if (cyc == 4) begin
            total++;
            if (Stall !== 1'b0) begin
               bad++; $display("FAIL timeout_stall_release got=%0b exp=0", Stall);
            end
         end
         tick();
      end
      total++;
      if (req_cnt != 4 || stall_cnt != 4) begin
         bad++; $display("FAIL timeout_cycles got req=%0d stall=%0d exp 4/4", req_cnt, stall_cnt);
      end
      total++;
      if (Err !== 1'b1 || RegWrite_Out !== 1'b0 || MemtoReg_Out !== 1'b1 || Rd_Out !== 5'd9 || mem_req !== 1'b0) begin
         bad++; $display("FAIL timeout_abort got err=%0b rw=%0b m2r=%0b rd=%0d req=%0b exp 1/0/1/9/0",
                         Err, RegWrite_Out, MemtoReg_Out, Rd_Out, mem_req);
      end
      clear_inputs();
      RegWrite_In = 1; Addr_In = 32'h20; Rd_In = 5'd4;
      tick(); tick(); tick();
      total++;
      if (Err !== 1'b1 || RegWrite_Out !== 1'b1 || ALUResult_Out !== 32'h20) begin
         bad++; $display("FAIL timeout_sticky got err=%0b rw=%0b alu=%h exp 1/1/20", Err, RegWrite_Out, ALUResult_Out);
      end
      clear_inputs();
      rst = 1;
      tick();
      rst = 0;
      total++;
      if (Err !== 1'b0) begin
         bad++; $display("FAIL timeout_err_clear got=%0b exp=0", Err);
      end
      $display("timeout transaction addr=200 checked");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_back_to_back();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
